// File: rtl/phy_reg_free_bitmap.sv
// Speculative + committed physical-register free bitmap.
// Rename clears, commit releases, flush restores from committed copy.
module phy_reg_free_bitmap #(
  parameter int ARCH_REGS = 32,
  parameter int LOW_WATER = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  alloc1_tag,
  input  logic [5:0]  alloc2_tag,
  input  logic        cmt1_valid,
  input  logic [5:0]  cmt1_new_tag,
  input  logic [5:0]  cmt1_old_tag,
  input  logic        cmt2_valid,
  input  logic [5:0]  cmt2_new_tag,
  input  logic [5:0]  cmt2_old_tag,
  input  logic        flush,
  output logic [0:63] free_vec,
  output logic [6:0]  free_cnt,
  output logic        low_water,
  output logic        err
);

  localparam logic [6:0] LW = 7'(LOW_WATER);
  localparam logic [6:0] RST_CNT = 7'(64 - ARCH_REGS);

  logic [0:63] s_q, c_q;
  logic [0:63] s_d, c_d;
  logic [0:63] rst_vec;
  logic [0:63] a_m, r_m, n_m;
  logic [6:0]  cnt_d;
  logic        viol;

  // tag 0 never contributes to a mask
  function automatic logic [0:63] onehot(input logic [5:0] t);
    logic [0:63] v;
    v = '0;
    if (t != 6'd0) v[t] = 1'b1;
    return v;
  endfunction

  // reset mapping: arch regs busy, remainder free, reg 0 busy
  always_comb begin
    rst_vec = '0;
    for (int i = 1; i < 64; i++)
      rst_vec[i] = (i >= ARCH_REGS);
  end

  // alloc / release / new-architectural masks
  always_comb begin
    a_m = onehot(alloc1_tag) | onehot(alloc2_tag);
    r_m = '0;
    n_m = '0;
    if (cmt1_valid) begin
      r_m = r_m | onehot(cmt1_old_tag);
      n_m = n_m | onehot(cmt1_new_tag);
    end
    if (cmt2_valid) begin
      r_m = r_m | onehot(cmt2_old_tag);
      n_m = n_m | onehot(cmt2_new_tag);
    end
  end

  // next bitmaps; flush takes the updated committed copy
  always_comb begin
    c_d = (c_q & ~n_m) | r_m;
    c_d[0] = 1'b0;
    if (flush) begin
      s_d = c_d;
    end else begin
      s_d = (s_q & ~a_m) | r_m;
    end
    s_d[0] = 1'b0;
  end

  // popcount of the next speculative bitmap
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < 64; i++)
      cnt_d = cnt_d + {6'd0, s_d[i]};
  end

  // protocol violation detection
  always_comb begin
    viol = 1'b0;
    if (alloc1_tag != 6'd0 && !s_q[alloc1_tag])
      viol = 1'b1;
    if (alloc2_tag != 6'd0 && !s_q[alloc2_tag])
      viol = 1'b1;
    if (alloc1_tag != 6'd0 && alloc1_tag == alloc2_tag)
      viol = 1'b1;
    if (cmt1_valid && cmt1_old_tag != 6'd0 &&
        s_q[cmt1_old_tag] && !a_m[cmt1_old_tag])
      viol = 1'b1;
    if (cmt2_valid && cmt2_old_tag != 6'd0 &&
        s_q[cmt2_old_tag] && !a_m[cmt2_old_tag])
      viol = 1'b1;
    if (cmt1_valid && cmt2_valid &&
        cmt1_old_tag != 6'd0 &&
        cmt1_old_tag == cmt2_old_tag)
      viol = 1'b1;
    if (cmt1_valid && cmt1_old_tag != 6'd0 &&
        cmt1_new_tag == cmt1_old_tag)
      viol = 1'b1;
    if (cmt2_valid && cmt2_old_tag != 6'd0 &&
        cmt2_new_tag == cmt2_old_tag)
      viol = 1'b1;
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q       <= rst_vec;
      c_q       <= rst_vec;
      free_cnt  <= RST_CNT;
      low_water <= 1'b0;
      err       <= 1'b0;
    end else begin
      s_q       <= s_d;
      c_q       <= c_d;
      free_cnt  <= cnt_d;
      low_water <= (cnt_d < LW);
      err       <= err | viol;
    end
  end

  assign free_vec = s_q;

endmodule

// File: tb/tb_phy_reg_free_bitmap.sv
// Bench for phy_reg_free_bitmap.
// Directed plan steps, then random traffic against a bitmap model.
module tb_phy_reg_free_bitmap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  a1, a2, n1, o1, n2, o2;
  logic        v1, v2, fl;
  logic [0:63] free_vec;
  logic [6:0]  free_cnt;
  logic        low_water, err;

  int total = 0;
  int bad = 0;

  bit sm[64];
  bit cm[64];
  bit em;

  phy_reg_free_bitmap dut (
    .clk(clk), .rst_n(rst_n),
    .alloc1_tag(a1), .alloc2_tag(a2),
    .cmt1_valid(v1), .cmt1_new_tag(n1),
    .cmt1_old_tag(o1),
    .cmt2_valid(v2), .cmt2_new_tag(n2),
    .cmt2_old_tag(o2),
    .flush(fl),
    .free_vec(free_vec), .free_cnt(free_cnt),
    .low_water(low_water), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int mcount();
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'(sm[i]);
    return c;
  endfunction

  function automatic logic [5:0] pick(
    input bit want, input logic [5:0] ex);
    int s = $urandom_range(1, 63);
    for (int k = 0; k < 63; k++) begin
      int t = 1 + (s - 1 + k) % 63;
      if (sm[t] == want && 6'(t) != ex)
        return 6'(t);
    end
    return 6'd0;
  endfunction

  task automatic idle_in();
    a1 = 0; a2 = 0; fl = 0;
    v1 = 0; n1 = 0; o1 = 0;
    v2 = 0; n2 = 0; o2 = 0;
  endtask

  // one cycle of the free-list rules, event by event
  task automatic model_step();
    bit ns[64];
    bit nc[64];
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        sm[i] = (i >= 32);
        cm[i] = (i >= 32);
      end
      em = 0;
      return;
    end
    if (a1 != 0 && !sm[a1]) em = 1;
    if (a2 != 0 && !sm[a2]) em = 1;
    if (a1 != 0 && a1 == a2) em = 1;
    if (v1 && o1 != 0 && sm[o1] &&
        o1 != a1 && o1 != a2) em = 1;
    if (v2 && o2 != 0 && sm[o2] &&
        o2 != a1 && o2 != a2) em = 1;
    if (v1 && v2 && o1 != 0 && o1 == o2) em = 1;
    if (v1 && o1 != 0 && n1 == o1) em = 1;
    if (v2 && o2 != 0 && n2 == o2) em = 1;
    nc = cm;
    if (v1) nc[n1] = 0;
    if (v2) nc[n2] = 0;
    if (v1) nc[o1] = 1;
    if (v2) nc[o2] = 1;
    nc[0] = 0;
    ns = sm;
    ns[a1] = 0;
    ns[a2] = 0;
    if (v1) ns[o1] = 1;
    if (v2) ns[o2] = 1;
    ns[0] = 0;
    if (fl) ns = nc;
    sm = ns;
    cm = nc;
  endtask

  task automatic chk(string tag,
    logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all(string tag);
    logic [0:63] ev;
    int c;
    for (int i = 0; i < 64; i++) ev[i] = sm[i];
    c = mcount();
    total++;
    assert (free_vec === ev) else begin
      bad++;
      $error("FAIL %s vec got=%h exp=%h",
        tag, free_vec, ev);
    end
    total++;
    assert (free_cnt === 7'(c)) else begin
      bad++;
      $error("FAIL %s cnt got=%0d exp=%0d",
        tag, free_cnt, c);
    end
    total++;
    assert (low_water === (c < 4)) else begin
      bad++;
      $error("FAIL %s lw got=%b exp=%b",
        tag, low_water, (c < 4));
    end
    total++;
    assert (err === em) else begin
      bad++;
      $error("FAIL %s err got=%b exp=%b",
        tag, err, em);
    end
  endtask

  task automatic cyc(string tag);
    model_step();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    logic [5:0] t1, t2;
    logic ok;
    int guard;

    idle_in();
    rst_n = 0;
    cyc("rst0");
    cyc("rst1");
    chk("rst_vec", free_vec, 64'h0000_0000_FFFF_FFFF);
    chk("rst_cnt", 64'(free_cnt), 64'd32);
    chk("rst_lw", 64'(low_water), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1;

    a1 = 32; a2 = 33;
    cyc("dual");
    chk("dual_cnt", 64'(free_cnt), 64'd30);
    chk("dual_b32", 64'(free_vec[32]), 64'd0);
    chk("dual_b33", 64'(free_vec[33]), 64'd0);
    idle_in();
    cyc("tag0");
    chk("tag0_cnt", 64'(free_cnt), 64'd30);

    v1 = 1; n1 = 32; o1 = 5;
    cyc("cmt");
    chk("cmt_b5", 64'(free_vec[5]), 64'd1);
    chk("cmt_cnt", 64'(free_cnt), 64'd31);

    for (int k = 0; k < 6; k++) begin
      idle_in();
      a1 = 6'(34 + 2 * k);
      a2 = 6'(35 + 2 * k);
      cyc("fl_alloc");
    end
    chk("pre_fl_cnt", 64'(free_cnt), 64'd19);
    idle_in();
    v2 = 1; n2 = 34; o2 = 7; fl = 1;
    cyc("flush");
    chk("fl_b7", 64'(free_vec[7]), 64'd1);
    chk("fl_b32", 64'(free_vec[32]), 64'd0);
    chk("fl_b34", 64'(free_vec[34]), 64'd0);
    ok = 1;
    for (int i = 35; i <= 45; i++) ok &= free_vec[i];
    chk("fl_35_45", 64'(ok), 64'd1);
    chk("fl_cnt", 64'(free_cnt), 64'd32);

    guard = 0;
    while (mcount() > 4 && guard < 40) begin
      idle_in();
      a1 = pick(1, 0);
      if (mcount() > 5) a2 = pick(1, a1);
      cyc("lw_alloc");
      guard++;
    end
    chk("lw4_cnt", 64'(free_cnt), 64'd4);
    chk("lw4_lw", 64'(low_water), 64'd0);
    idle_in();
    t1 = pick(1, 0);
    t2 = pick(1, t1);
    a1 = t1; a2 = t2;
    cyc("lw_pair");
    chk("lw2_cnt", 64'(free_cnt), 64'd2);
    chk("lw2_lw", 64'(low_water), 64'd1);
    idle_in();
    v1 = 1; o1 = t1; n1 = t2;
    v2 = 1; o2 = t2; n2 = t1;
    cyc("lw_rel");
    chk("lwr_cnt", 64'(free_cnt), 64'd4);
    chk("lwr_lw", 64'(low_water), 64'd0);
    chk("lwr_err", 64'(err), 64'd0);

    idle_in();
    rst_n = 0;
    cyc("e_rst");
    rst_n = 1;
    v1 = 1; o1 = 40; n1 = 41;
    cyc("rel40");
    chk("rel40_err", 64'(err), 64'd1);
    idle_in();
    fl = 1;
    cyc("e_flush");
    chk("e_fl_err", 64'(err), 64'd1);
    idle_in();
    cyc("e_idle");
    chk("e_idle_err", 64'(err), 64'd1);
    rst_n = 0;
    cyc("e_rst2");
    chk("e_rst_err", 64'(err), 64'd0);
    rst_n = 1;
    a1 = 50; a2 = 50;
    cyc("dup50");
    chk("dup50_err", 64'(err), 64'd1);

    idle_in();
    rst_n = 0;
    cyc("r_rst");
    rst_n = 1;
    for (int k = 0; k < 400; k++) begin
      idle_in();
      if ($urandom_range(0, 3) != 0) a1 = pick(1, 0);
      if ($urandom_range(0, 2) != 0) a2 = pick(1, a1);
      if ($urandom_range(0, 2) == 0) begin
        v1 = 1;
        o1 = pick(0, 0);
        n1 = pick(0, o1);
      end
      if ($urandom_range(0, 2) == 0) begin
        v2 = 1;
        o2 = pick(0, o1);
        n2 = pick(0, o2);
      end
      fl = ($urandom_range(0, 15) == 0);
      cyc("rand");
    end
    chk("rand_err", 64'(err), 64'd0);

    for (int k = 0; k < 200; k++) begin
      a1 = 6'($urandom); a2 = 6'($urandom);
      v1 = 1'($urandom); v2 = 1'($urandom);
      n1 = 6'($urandom); o1 = 6'($urandom);
      n2 = 6'($urandom); o2 = 6'($urandom);
      fl = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 19) != 0);
      cyc("chaos");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
